j0_bus_responder: RTL and testbench
===================================

// Module: j0_bus_responder
// PURPOSE
// - Slave end of the j0 data bus: serves mem_rd/mem_wr/mem_addr/mem_dout, returns mem_din, generates pause.
// - Zero-wait local scratch RAM and control registers. External shared memory behind a req/ack port uses a 1-entry posted write buffer.
// - Sits between the j0 core and the synth register file / host memory arbiter.
// PARAMETERS
// - RAM_AW     8    scratch RAM address width (2**RAM_AW x 16 words)
// - REG_COUNT  16   number of 16-bit control registers (max 16)
// - TIMEOUT    255  ext_ack wait limit in cycles (used only with J0_BUS_TIMEOUT_EN)
// PORTS
// - sys_clk_i    in   1              clock
// - sys_rst_n_i  in   1              async active-low reset
// - mem_rd       in   1              j0 read strobe (not masked by pause)
// - mem_wr       in   1              j0 write strobe (forced low by j0 while pause=1)
// - mem_addr     in   16             j0 address (= T, always driven)
// - mem_dout     in   16             j0 write data
// - mem_din      out  16             read data; combinational, valid in the same cycle as mem_rd
// - pause        out  1              stall j0; combinational
// - regs_o       out  16*REG_COUNT   control register contents, reg i at [16*i+15:16*i]
// - ext_req_o    out  1              external access request
// - ext_we_o     out  1              1=write, 0=read
// - ext_addr_o   out  15             word address (mem_addr[14:0])
// - ext_wdata_o  out  16             write data
// - ext_rdata_i  in   16             read data, valid with ext_ack_i
// - ext_ack_i    in   1              one-cycle completion
// - err_o        out  1              sticky timeout flag; tied 0 without J0_BUS_TIMEOUT_EN
// BEHAVIOUR
// - Map: RAM  addr[15:RAM_AW]==0. REG  addr[15:4]==12'h010, index addr[3:0] < REG_COUNT. EXT  addr[15]==1. All else unmapped: reads 16'h0000, writes dropped.
// - RAM/REG: write on the clock edge when mem_wr=1. Read is combinational from the array or register. Never pauses.
// - EXT port FSM: IDLE, WR_BUSY, RD_REQ, RD_DONE.
// - ext_req_o and ext_addr_o/ext_we_o/ext_wdata_o are held stable from request until the edge that samples ext_ack_i=1. ext_req_o drops the next cycle.
// - Ack in the first request cycle is legal. Ack when no request is pending is ignored.
// - EXT write, IDLE: posted. Address/data are latched, go to WR_BUSY, no pause. Return to IDLE on ack.
// - EXT read, IDLE: pause=1 combinationally in that cycle, go to RD_REQ.
//   - On ack, latch ext_rdata_i and go to RD_DONE.
//   - RD_DONE: pause=0, mem_din = latch for exactly one cycle, then IDLE.
//   - Minimum read cost: 2 stalled cycles plus ack latency.
// - EXT rd/wr while WR_BUSY (ordering):
//   - Set the stalled flag. pause=1 until the buffer drains.
//   - Then drop pause and re-evaluate the same access next cycle. mem_wr re-asserts once pause is low.
// - pause = stalled | (state==RD_REQ) | (mem_rd & EXT & state==IDLE).
// - mem_rd and mem_wr both high in one cycle: treated as a write; mem_din still returns the read value for RAM/REG.
// - Reset (async, any time, including mid-transaction):
//   - FSM to IDLE, stalled=0, ext_req_o=0, err_o=0, regs_o=0.
//   - Pending buffered write is discarded. RAM contents are not cleared.
// CONFIGURATION
// - J0_BUS_TIMEOUT_EN defined:
//   - An 8-bit counter runs while ext_req_o=1. When it reaches TIMEOUT without ack, the transaction aborts: req drops, err_o sets (sticky until reset).
//   - An aborted read completes through RD_DONE with data 16'hDEAD.
//   - Counter clears on every new request.
// - Not defined: no counter, waits for ack forever, err_o=0.
// STRUCTURE
// - Package j0_bus_pkg: address-map constants (RAM base, REG_BASE=12'h010, EXT bit 15), FSM state encoding, TIMEOUT_DATA=16'hDEAD.
// - Sub-module j0_ext_port: FSM, write buffer, read latch, stalled flag, timeout.
// - Top level holds the decode, RAM, regs and mem_din mux.
// TESTING
// - RAM: wr 0x0012<=16'hA5A5, then rd 0x0012 -> mem_din=16'hA5A5 in the same cycle, pause never 1.
// - REG: wr 0x0103<=16'h1234 -> regs_o[63:48]=16'h1234 next cycle. Rd 0x0200 -> 16'h0000.
// - EXT rd 0x8004, ack 3 cycles after req with rdata 16'hBEEF -> pause high 5 cycles, ext_addr_o=15'h0004, mem_din=16'hBEEF in the first unpaused cycle.
// - Back-to-back EXT wr 0x8000<=1 then wr 0x8001<=2, ack delay 4:
//   - first write posts with no pause; second stalls until ack #1;
//   - ext sees write 0x0000 then 0x0001, in order.
// - Assert sys_rst_n_i low during RD_REQ -> ext_req_o=0 and pause=0 immediately; IDLE after release.
// - With J0_BUS_TIMEOUT_EN and no ack: EXT rd -> aborts after 255 cycles, mem_din=16'hDEAD, err_o=1 held until reset.

Source files
------------

// File: rtl/j0_bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// j0_bus_pkg
// Shared constants and types for the j0 data-bus responder:
//   - address map: scratch RAM base, control-register block base, EXT select bit
//   - external-port FSM state encoding
//   - data returned by a read that was aborted by the ack timeout
// -----------------------------------------------------------------------------
package j0_bus_pkg;

    localparam logic [15:0] RAM_BASE     = 16'h0000;
    localparam logic [11:0] REG_BASE     = 12'h010;   // compared against addr[15:4]
    localparam int          EXT_BIT      = 15;
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_BUSY = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_DONE = 2'd3
    } ext_state_e;

endpackage

// File: rtl/j0_bus_responder_if.sv
// -----------------------------------------------------------------------------
// j0_bus_if
// j0 core data bus.
//   mem_rd    j0 read strobe (not masked by pause)
//   mem_wr    j0 write strobe (held low by the j0 while pause=1)
//   mem_addr  word address (the j0 T register, always driven)
//   mem_dout  write data from the j0
//   mem_din   read data back to the j0, combinational
//   pause     stall request to the j0, combinational
// Modports: master = j0 core side, slave = responder side.
// -----------------------------------------------------------------------------
interface j0_bus_if;

    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_dout;
    logic [15:0] mem_din;
    logic        pause;

    modport master (
        output mem_rd, mem_wr, mem_addr, mem_dout,
        input  mem_din, pause
    );

    modport slave (
        input  mem_rd, mem_wr, mem_addr, mem_dout,
        output mem_din, pause
    );

endinterface

// File: rtl/j0_bus_responder_ext_port.sv
// -----------------------------------------------------------------------------
// j0_ext_port
// External shared-memory port of the j0 bus responder: request/ack FSM with a
// one-entry posted write buffer, read-data latch, ordering stall and optional
// ack timeout.
// Optional feature macro: J0_BUS_TIMEOUT_EN (ack timeout, sticky err_o).
// Ports:
//   clk_i, rst_n_i     clock, async active-low reset
//   sel_i              current j0 address targets the EXT window
//   rd_i, wr_i         j0 strobes
//   addr_i, wdata_i    j0 word address [14:0] and write data
//   pause_o            stall to the j0 (combinational)
//   rd_valid_o         read result is presented this cycle
//   rd_data_o          latched read result
//   ext_*              external request/ack port
//   err_o              sticky timeout flag
// -----------------------------------------------------------------------------
module j0_ext_port
    import j0_bus_pkg::*;
`ifdef J0_BUS_TIMEOUT_EN
#(
    parameter int TIMEOUT = 255
)
`endif
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        sel_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [14:0] addr_i,
    input  logic [15:0] wdata_i,
    output logic        pause_o,
    output logic        rd_valid_o,
    output logic [15:0] rd_data_o,
    output logic        ext_req_o,
    output logic        ext_we_o,
    output logic [14:0] ext_addr_o,
    output logic [15:0] ext_wdata_o,
    input  logic [15:0] ext_rdata_i,
    input  logic        ext_ack_i,
    output logic        err_o
);

    ext_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        stalled_q, stalled_d;
    logic        we_q, we_d;
    logic [14:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

    logic wr_acc;
    logic rd_acc;
    logic stall_set;
    logic launch;
    logic done;
    logic abort;

    // A simultaneous rd+wr is a write.
    assign wr_acc    = sel_i & wr_i;
    assign rd_acc    = sel_i & rd_i & ~wr_i;
    // Any EXT access while the posted write is still outstanding must wait so
    // the external side sees accesses in program order.
    assign stall_set = (state_q == ST_WR_BUSY) & (wr_acc | rd_acc);
    assign launch    = (state_q == ST_IDLE) & (wr_acc | rd_acc);
    // Ack outside an outstanding request is ignored.
    assign done      = req_q & ext_ack_i;

`ifdef J0_BUS_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // Counter holds the number of completed request cycles; abort on the
    // TIMEOUT-th request cycle that still has no ack.
    assign abort = req_q & ~ext_ack_i & (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | abort;
        if (launch) begin
            cnt_d = 8'd0;
        end else if (req_q) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign err_o = err_q;
`else
    assign abort = 1'b0;
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            stalled_q <= stalled_d;
        end
    end

    // Transaction payload needs no reset: it is only looked at while req_q=1
    // or in RD_DONE, both of which start from a fresh capture.
    always_ff @(posedge clk_i) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        stalled_d = stalled_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;

        pause_o = stalled_q | stall_set | (state_q == ST_RD_REQ) |
                  ((state_q == ST_IDLE) & rd_acc);

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    addr_d = addr_i;
                    we_d   = wr_acc;
                    req_d  = 1'b1;
                    if (wr_acc) begin
                        wdata_d = wdata_i;
                        state_d = ST_WR_BUSY;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_WR_BUSY: begin
                if (stall_set) begin
                    stalled_d = 1'b1;
                end
                // Drain releases the stall; the held access is re-evaluated
                // from IDLE on the following cycle.
                if (done || abort) begin
                    req_d     = 1'b0;
                    stalled_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (done) begin
                    rdata_d = ext_rdata_i;
                    req_d   = 1'b0;
                    state_d = ST_RD_DONE;
                end else if (abort) begin
                    rdata_d = TIMEOUT_DATA;
                    req_d   = 1'b0;
                    state_d = ST_RD_DONE;
                end
            end
            ST_RD_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rd_valid_o  = (state_q == ST_RD_DONE);
    assign rd_data_o   = rdata_q;
    assign ext_req_o   = req_q;
    assign ext_we_o    = we_q;
    assign ext_addr_o  = addr_q;
    assign ext_wdata_o = wdata_q;

endmodule

// File: rtl/j0_bus_responder.sv
// -----------------------------------------------------------------------------
// j0_bus_responder
// Slave end of the j0 data bus. Decodes the address, holds the zero-wait
// scratch RAM and control registers, muxes read data, and hands EXT accesses
// to j0_ext_port.
// Optional feature macro: J0_BUS_TIMEOUT_EN (ack timeout, sticky err_o).
// Map: RAM  addr[15:RAM_AW]==0
//      REG  addr[15:4]==12'h010 and addr[3:0] < REG_COUNT
//      EXT  addr[15]==1
//      anything else reads 0, writes are dropped.
// Ports:
//   sys_clk_i, sys_rst_n_i  clock, async active-low reset
//   bus                     j0 data bus (slave modport)
//   regs_o                  control registers, reg i at [16*i+15:16*i]
//   ext_req_o/ext_we_o/ext_addr_o/ext_wdata_o/ext_rdata_i/ext_ack_i
//                           external shared-memory port
//   err_o                   sticky ack-timeout flag
// -----------------------------------------------------------------------------
module j0_bus_responder
    import j0_bus_pkg::*;
#(
    parameter int RAM_AW    = 8,
    parameter int REG_COUNT = 16,
    parameter int TIMEOUT   = 255
)(
    input  logic                    sys_clk_i,
    input  logic                    sys_rst_n_i,
    j0_bus_if.slave                 bus,
    output logic [16*REG_COUNT-1:0] regs_o,
    output logic                    ext_req_o,
    output logic                    ext_we_o,
    output logic [14:0]             ext_addr_o,
    output logic [15:0]             ext_wdata_o,
    input  logic [15:0]             ext_rdata_i,
    input  logic                    ext_ack_i,
    output logic                    err_o
);

    if (REG_COUNT < 1 || REG_COUNT > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("j0_bus_responder: REG_COUNT must be 1..16 and TIMEOUT 1..255");
    end

    localparam logic [4:0] REG_LIMIT = 5'(REG_COUNT);

    logic              ram_sel;
    logic              reg_sel;
    logic              ext_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic [3:0]        reg_idx;
    logic              ext_pause;
    logic              ext_rd_valid;
    logic [15:0]       ext_rd_data;

    logic [15:0] ram_q  [2**RAM_AW];
    logic [15:0] regs_q [REG_COUNT];

    assign ram_idx = bus.mem_addr[RAM_AW-1:0];
    assign reg_idx = bus.mem_addr[3:0];
    assign ram_sel = (bus.mem_addr[15:RAM_AW] == RAM_BASE[15:RAM_AW]);
    assign reg_sel = (bus.mem_addr[15:4] == REG_BASE) && ({1'b0, reg_idx} < REG_LIMIT);
    assign ext_sel = bus.mem_addr[EXT_BIT];

    // Scratch RAM keeps its contents across reset.
    always_ff @(posedge sys_clk_i) begin
        if (bus.mem_wr && ram_sel) begin
            ram_q[ram_idx] <= bus.mem_dout;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (bus.mem_wr && reg_sel) begin
            regs_q[reg_idx] <= bus.mem_dout;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            regs_o[16*i +: 16] = regs_q[i];
        end
    end

    // The EXT read result wins for its single RD_DONE cycle; the j0 still
    // presents the EXT address then, so no other source would match anyway.
    always_comb begin
        bus.mem_din = 16'h0000;
        if (ext_rd_valid) begin
            bus.mem_din = ext_rd_data;
        end else if (ram_sel) begin
            bus.mem_din = ram_q[ram_idx];
        end else if (reg_sel) begin
            bus.mem_din = regs_q[reg_idx];
        end
    end

    assign bus.pause = ext_pause;

    j0_ext_port
`ifdef J0_BUS_TIMEOUT_EN
    #(
        .TIMEOUT (TIMEOUT)
    )
`endif
    u_ext_port (
        .clk_i       (sys_clk_i),
        .rst_n_i     (sys_rst_n_i),
        .sel_i       (ext_sel),
        .rd_i        (bus.mem_rd),
        .wr_i        (bus.mem_wr),
        .addr_i      (bus.mem_addr[14:0]),
        .wdata_i     (bus.mem_dout),
        .pause_o     (ext_pause),
        .rd_valid_o  (ext_rd_valid),
        .rd_data_o   (ext_rd_data),
        .ext_req_o   (ext_req_o),
        .ext_we_o    (ext_we_o),
        .ext_addr_o  (ext_addr_o),
        .ext_wdata_o (ext_wdata_o),
        .ext_rdata_i (ext_rdata_i),
        .ext_ack_i   (ext_ack_i),
        .err_o       (err_o)
    );

endmodule

// File: tb/tb_j0_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_j0_bus_responder
// Directed bench for j0_bus_responder: RAM, control registers, unmapped space,
// EXT read, posted EXT writes with ordering stall, reset mid-transaction, and
// (with J0_BUS_TIMEOUT_EN) the ack timeout.
// Inputs change 1 time unit after the rising edge; outputs are looked at
// 3 units after the edge.
// -----------------------------------------------------------------------------
module tb_j0_bus_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] regs_o;
    logic         ext_req;
    logic         ext_we;
    logic [14:0]  ext_addr;
    logic [15:0]  ext_wdata;
    logic [15:0]  ext_rdata = 16'h0000;
    logic         ext_ack = 1'b0;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [255:0] regs_exp;

    j0_bus_if bus_if ();

    j0_bus_responder dut (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rst_n),
        .bus         (bus_if),
        .regs_o      (regs_o),
        .ext_req_o   (ext_req),
        .ext_we_o    (ext_we),
        .ext_addr_o  (ext_addr),
        .ext_wdata_o (ext_wdata),
        .ext_rdata_i (ext_rdata),
        .ext_ack_i   (ext_ack),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_if.mem_rd   = 1'b0;
        bus_if.mem_wr   = 1'b0;
        bus_if.mem_addr = 16'h0000;
        bus_if.mem_dout = 16'h0000;
        regs_exp        = '0;

        // Reset state
        @(posedge clk);
        #2;
        chk("rst_pause", bus_if.pause, 1'b0);
        chk("rst_req", ext_req, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_regs", regs_o, '0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // RAM write then same-cycle read
        bus_if.mem_wr = 1'b1; bus_if.mem_addr = 16'h0012; bus_if.mem_dout = 16'hA5A5;
        #2; chk("ram_wr_pause", bus_if.pause, 1'b0);
        cyc();
        bus_if.mem_wr = 1'b0; bus_if.mem_rd = 1'b1;
        #2; chk("ram_rd_data", bus_if.mem_din, 16'hA5A5);
        chk("ram_rd_pause", bus_if.pause, 1'b0);
        cyc();
        // rd+wr together: write happens, read returns the old word
        bus_if.mem_wr = 1'b1; bus_if.mem_dout = 16'h1111;
        #2; chk("ram_rdwr_old", bus_if.mem_din, 16'hA5A5);
        cyc();
        bus_if.mem_wr = 1'b0;
        #2; chk("ram_rdwr_new", bus_if.mem_din, 16'h1111);
        cyc();
        // Top RAM word
        bus_if.mem_rd = 1'b0; bus_if.mem_wr = 1'b1; bus_if.mem_addr = 16'h00FF; bus_if.mem_dout = 16'h7777;
        cyc();
        bus_if.mem_wr = 1'b0; bus_if.mem_rd = 1'b1;
        #2; chk("ram_top", bus_if.mem_din, 16'h7777);
        cyc();

        // Control registers
        bus_if.mem_rd = 1'b0; bus_if.mem_wr = 1'b1; bus_if.mem_addr = 16'h0103; bus_if.mem_dout = 16'h1234;
        cyc();
        bus_if.mem_wr = 1'b0;
        regs_exp[63:48] = 16'h1234;
        #2; chk("reg3_field", regs_o[63:48], 16'h1234);
        chk("regs_all_a", regs_o, regs_exp);
        bus_if.mem_rd = 1'b1;
        #1; chk("reg3_rd", bus_if.mem_din, 16'h1234);
        cyc();
        bus_if.mem_rd = 1'b0; bus_if.mem_wr = 1'b1; bus_if.mem_addr = 16'h010F; bus_if.mem_dout = 16'hCAFE;
        cyc();
        regs_exp[255:240] = 16'hCAFE;
        // Unmapped write must be dropped, unmapped read returns 0
        bus_if.mem_addr = 16'h0200; bus_if.mem_dout = 16'hFFFF;
        cyc();
        bus_if.mem_wr = 1'b0; bus_if.mem_rd = 1'b1;
        #2; chk("unmapped_rd", bus_if.mem_din, 16'h0000);
        chk("regs_all_b", regs_o, regs_exp);
        bus_if.mem_addr = 16'h0110;
        #1; chk("reg_past_end_rd", bus_if.mem_din, 16'h0000);
        cyc();

        // EXT read, ack 3 cycles after req rises: 5 paused cycles
        bus_if.mem_addr = 16'h8004;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                ext_ack = 1'b1; ext_rdata = 16'hBEEF;
            end
            #2; chk($sformatf("extrd_pause_c%0d", i), bus_if.pause, 1'b1);
            chk($sformatf("extrd_req_c%0d", i), ext_req, (i != 0));
            if (i >= 1) begin
                chk("extrd_addr", ext_addr, 15'h0004);
                chk("extrd_we", ext_we, 1'b0);
            end
            cyc();
        end
        ext_ack = 1'b0; ext_rdata = 16'h0000;
        #2; chk("extrd_done_pause", bus_if.pause, 1'b0);
        chk("extrd_data", bus_if.mem_din, 16'hBEEF);
        chk("extrd_req_drop", ext_req, 1'b0);
        cyc();
        bus_if.mem_rd = 1'b0; bus_if.mem_addr = 16'h0000;
        #2; chk("extrd_idle_pause", bus_if.pause, 1'b0);
        cyc();

        // Back-to-back posted EXT writes, ack delay 4
        bus_if.mem_wr = 1'b1; bus_if.mem_addr = 16'h8000; bus_if.mem_dout = 16'h0001;
        #2; chk("wb1_pause", bus_if.pause, 1'b0);
        cyc();
        bus_if.mem_addr = 16'h8001; bus_if.mem_dout = 16'h0002;
        #2; chk("wb2_stall", bus_if.pause, 1'b1);
        chk("wb1_req", ext_req, 1'b1);
        chk("wb1_we", ext_we, 1'b1);
        chk("wb1_addr", ext_addr, 15'h0000);
        chk("wb1_data", ext_wdata, 16'h0001);
        cyc();
        bus_if.mem_wr = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            if (i == 5) ext_ack = 1'b1;
            #2; chk($sformatf("wb2_stall_c%0d", i), bus_if.pause, 1'b1);
            chk("wb1_addr_hold", ext_addr, 15'h0000);
            cyc();
        end
        ext_ack = 1'b0; bus_if.mem_wr = 1'b1;
        #2; chk("wb2_release", bus_if.pause, 1'b0);
        chk("wb1_req_drop", ext_req, 1'b0);
        cyc();
        bus_if.mem_wr = 1'b0; ext_ack = 1'b1;
        #2; chk("wb2_req", ext_req, 1'b1);
        chk("wb2_addr", ext_addr, 15'h0001);
        chk("wb2_data", ext_wdata, 16'h0002);
        chk("wb2_we", ext_we, 1'b1);
        chk("wb2_nopause", bus_if.pause, 1'b0);
        cyc();
        ext_ack = 1'b0;
        #2; chk("wb2_req_drop", ext_req, 1'b0);
        // Stray ack with nothing outstanding
        ext_ack = 1'b1;
        cyc();
        ext_ack = 1'b0;
        #2; chk("stray_ack_req", ext_req, 1'b0);
        chk("stray_ack_pause", bus_if.pause, 1'b0);
        cyc();

        // EXT read behind a posted write, first-cycle acks
        bus_if.mem_wr = 1'b1; bus_if.mem_addr = 16'h8010; bus_if.mem_dout = 16'h0003;
        cyc();
        bus_if.mem_wr = 1'b0; bus_if.mem_rd = 1'b1; bus_if.mem_addr = 16'h8011; ext_ack = 1'b1;
        #2; chk("rbw_stall", bus_if.pause, 1'b1);
        chk("rbw_wr_addr", ext_addr, 15'h0010);
        chk("rbw_wr_data", ext_wdata, 16'h0003);
        cyc();
        ext_ack = 1'b0;
        #2; chk("rbw_idle_pause", bus_if.pause, 1'b1);
        chk("rbw_idle_req", ext_req, 1'b0);
        cyc();
        ext_ack = 1'b1; ext_rdata = 16'h5555;
        #2; chk("rbw_rd_req", ext_req, 1'b1);
        chk("rbw_rd_addr", ext_addr, 15'h0011);
        chk("rbw_rd_we", ext_we, 1'b0);
        cyc();
        ext_ack = 1'b0; ext_rdata = 16'h0000;
        #2; chk("rbw_rd_data", bus_if.mem_din, 16'h5555);
        chk("rbw_rd_pause", bus_if.pause, 1'b0);
        cyc();
        bus_if.mem_rd = 1'b0; bus_if.mem_addr = 16'h0000;
        cyc();

        // Reset while in RD_REQ
        bus_if.mem_rd = 1'b1; bus_if.mem_addr = 16'h8020;
        cyc();
        #2; chk("rstmid_req_before", ext_req, 1'b1);
        rst_n = 1'b0; bus_if.mem_rd = 1'b0; bus_if.mem_addr = 16'h0000;
        #1; chk("rstmid_req", ext_req, 1'b0);
        chk("rstmid_pause", bus_if.pause, 1'b0);
        chk("rstmid_regs", regs_o, '0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #2; chk("rstrel_req", ext_req, 1'b0);
        chk("rstrel_pause", bus_if.pause, 1'b0);
        bus_if.mem_rd = 1'b1; bus_if.mem_addr = 16'h0012;
        #1; chk("ram_kept", bus_if.mem_din, 16'h1111);
        cyc();
        bus_if.mem_rd = 1'b0; bus_if.mem_wr = 1'b1; bus_if.mem_addr = 16'h8030; bus_if.mem_dout = 16'h0BAD;
        #2; chk("rstrel_wr_pause", bus_if.pause, 1'b0);
        cyc();
        bus_if.mem_wr = 1'b0; ext_ack = 1'b1;
        #2; chk("rstrel_wr_req", ext_req, 1'b1);
        chk("rstrel_wr_addr", ext_addr, 15'h0030);
        chk("rstrel_wr_data", ext_wdata, 16'h0BAD);
        cyc();
        ext_ack = 1'b0;
        #2; chk("rstrel_wr_done", ext_req, 1'b0);
        cyc();

`ifdef J0_BUS_TIMEOUT_EN
        // EXT read with no ack: abort after 255 request cycles
        begin
            int  npause;
            int  nreq;
            bit  got;
            npause = 0; nreq = 0; got = 1'b0;
            bus_if.mem_rd = 1'b1; bus_if.mem_addr = 16'h8040;
            for (int i = 0; i < 400 && !got; i++) begin
                #2;
                if (bus_if.pause) begin
                    npause++;
                    if (ext_req) nreq++;
                    cyc();
                end else begin
                    got = 1'b1;
                end
            end
            chk("to_completed", got, 1'b1);
            chk("to_pause_cycles", npause, 256);
            chk("to_req_cycles", nreq, 255);
            chk("to_data", bus_if.mem_din, 16'hDEAD);
            chk("to_err", err, 1'b1);
            chk("to_req_drop", ext_req, 1'b0);
            cyc();
            bus_if.mem_rd = 1'b0; bus_if.mem_addr = 16'h0000;
            cyc();
            cyc();
            #2; chk("to_err_sticky", err, 1'b1);
            rst_n = 1'b0;
            #1; chk("to_err_reset", err, 1'b0);
            cyc();
            rst_n = 1'b1;
            cyc();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
